// File: rtl/duck_pkg.sv
// duck_pkg: shared types and constants for the duck sprite read path.
//   duck_state_t  - duck behaviour state driven by the game logic
//   FR_*          - frame RAM select codes (which duck image RAM feeds ram_rd_data)
//   PALETTE       - 8-entry index -> 24-bit RGB table (index 0 is transparent)
package duck_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLYING  = 2'd1,
        SHOT    = 2'd2,
        FALLING = 2'd3
    } duck_state_t;

    localparam int SPR_W_DEF = 20;
    localparam int SPR_H_DEF = 20;

    localparam logic [2:0] FR_FLY0  = 3'd0;
    localparam logic [2:0] FR_FLY1  = 3'd1;
    localparam logic [2:0] FR_FLY2  = 3'd2;
    localparam logic [2:0] FR_SHOT  = 3'd3;
    localparam logic [2:0] FR_FALL0 = 3'd4;
    localparam logic [2:0] FR_FALL1 = 3'd5;

    localparam logic [23:0] PALETTE [0:7] = '{
        24'h000000,   // transparent
        24'h101010,   // outline
        24'h1E6B24,   // head green
        24'h8B4513,   // body brown
        24'hFFFFFF,   // wing white
        24'hFFA500,   // beak orange
        24'hE8C468,   // belly tan
        24'hFF0000    // eye red
    };

    function automatic logic [2:0] first_frame(input duck_state_t s);
        case (s)
            SHOT:    return FR_SHOT;
            FALLING: return FR_FALL0;
            default: return FR_FLY0;
        endcase
    endfunction

    // Flap phase 0..3 walks the wing frames 0,1,2,1 so the wing swings back.
    function automatic logic [2:0] fly_frame(input logic [1:0] ph);
        case (ph)
            2'd0:    return FR_FLY0;
            2'd2:    return FR_FLY2;
            default: return FR_FLY1;
        endcase
    endfunction

endpackage

// File: rtl/duck_palette.sv
// duck_palette: combinational palette lookup, registered by the parent.
//   idx  in  3   palette index from the frame RAM
//   rgb  out 24  {R,G,B}
module duck_palette
    import duck_pkg::*;
(
    input  logic [2:0]  idx,
    output logic [23:0] rgb
);
    assign rgb = PALETTE[idx];
endmodule

// File: rtl/duck_sprite_renderer.sv
// duck_sprite_renderer: per-pixel read driver for the duck frame RAMs.
//   Clk, Reset_n            clock / async active-low reset
//   DrawX, DrawY            scan coordinate
//   SpriteX, SpriteY, dir_left  duck placement, latched on frame_tick
//   duck_state, frame_tick  animation control
//   ram_rd_addr, ram_frame_sel  frame RAM read address / RAM select
//   ram_rd_data             selected RAM output ([2:0] = palette index)
//   fall_start              one-cycle pulse once SHOT has been held
//   sprite_on, Red/Green/Blue   opaque flag and colour, 3 edges after DrawX/DrawY
module duck_sprite_renderer
    import duck_pkg::*;
#(
    parameter int SPR_W      = SPR_W_DEF,
    parameter int SPR_H      = SPR_H_DEF,
    parameter int ADDR_W     = 19,
    parameter int FLAP_DIV   = 8,
    parameter int SHOT_HOLD  = 30,
    parameter int TRANSP_IDX = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    input  logic              dir_left,
    input  duck_state_t       duck_state,
    input  logic              frame_tick,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [2:0]        ram_frame_sel,
    input  logic [4:0]        ram_rd_data,
    output logic              fall_start,
    output logic              sprite_on,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue
);
    localparam int CW = 8;

    logic [9:0]        spr_x_l, spr_y_l;
    logic              dir_l;
    logic [10:0]       dx, dy, col;
    logic              hit0;
    logic [ADDR_W-1:0] addr0;
    logic [1:0]        vld_pipe;
    logic [2:0]        idx;
    logic [23:0]       pal_rgb;
    logic              opaque;
    logic              unused_ram_hi;

    duck_state_t       cur_st;
    logic [CW-1:0]     cnt;
    logic [1:0]        fly_ph;
    logic              shot_fired;

    // 11-bit differences: bit 10 is the sign, so a sprite near x=1023
    // never aliases onto the left edge of the screen.
    always_comb begin
        dx    = {1'b0, DrawX} - {1'b0, spr_x_l};
        dy    = {1'b0, DrawY} - {1'b0, spr_y_l};
        hit0  = ~dx[10] & (dx < 11'(SPR_W)) & ~dy[10] & (dy < 11'(SPR_H));
        col   = dir_l ? (11'(SPR_W - 1) - dx) : dx;
        addr0 = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
    end

    assign idx           = ram_rd_data[2:0];
    assign unused_ram_hi = ^ram_rd_data[4:3];
    assign opaque        = vld_pipe[1] && (idx != 3'(TRANSP_IDX)) && (duck_state != IDLE);

    duck_palette u_pal (.idx(idx), .rgb(pal_rgb));

    // Placement latch: only moves during vertical blank.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            spr_x_l <= '0;
            spr_y_l <= '0;
            dir_l   <= 1'b0;
        end else if (frame_tick) begin
            spr_x_l <= SpriteX;
            spr_y_l <= SpriteY;
            dir_l   <= dir_left;
        end
    end

    // Pixel pipe: addr reg -> RAM read -> colour reg.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ram_rd_addr        <= '0;
            vld_pipe           <= '0;
            sprite_on          <= 1'b0;
            {Red, Green, Blue} <= '0;
        end else begin
            ram_rd_addr        <= hit0 ? addr0 : '0;
            vld_pipe           <= {vld_pipe[0], hit0};
            sprite_on          <= opaque;
            {Red, Green, Blue} <= opaque ? pal_rgb : 24'h0;
        end
    end

    // Animation sequencer; the tick that sees a new state is tick 1 of it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_st        <= IDLE;
            cnt           <= '0;
            fly_ph        <= '0;
            shot_fired    <= 1'b0;
            ram_frame_sel <= '0;
            fall_start    <= 1'b0;
        end else begin
            fall_start <= 1'b0;
            if (frame_tick) begin
                if (duck_state != cur_st) begin
                    cur_st        <= duck_state;
                    cnt           <= '0;
                    fly_ph        <= '0;
                    shot_fired    <= 1'b0;
                    ram_frame_sel <= first_frame(duck_state);
                    if (duck_state == SHOT && SHOT_HOLD <= 1) begin
                        fall_start <= 1'b1;
                        shot_fired <= 1'b1;
                    end
                end else begin
                    case (cur_st)
                        IDLE: begin
                            cnt           <= '0;
                            ram_frame_sel <= FR_FLY0;
                        end
                        FLYING: begin
                            if (cnt == CW'(FLAP_DIV - 1)) begin
                                cnt           <= '0;
                                fly_ph        <= 2'(fly_ph + 2'd1);
                                ram_frame_sel <= fly_frame(2'(fly_ph + 2'd1));
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        FALLING: begin
                            if (cnt == CW'(FLAP_DIV - 1)) begin
                                cnt           <= '0;
                                ram_frame_sel <= (ram_frame_sel == FR_FALL0) ? FR_FALL1 : FR_FALL0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        SHOT: begin
                            // Counter freezes once fired so it can never wrap and re-fire.
                            if (!shot_fired) begin
                                if (cnt == CW'(SHOT_HOLD - 2)) begin
                                    fall_start <= 1'b1;
                                    shot_fired <= 1'b1;
                                end
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
